// File: rtl/decode_imm_stage_pkg.sv
// Shared definitions for the decode/immediate stage: RV32I opcodes, the
// immediate-type encoding, the NOP default and the buffered entry format.
package decode_imm_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_IR_DEFAULT = 32'h00000013;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_I    = 3'd1,
    SEL_S    = 3'd2,
    SEL_B    = 3'd3,
    SEL_U    = 3'd4,
    SEL_J    = 3'd5
  } imm_sel_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] imm;
    imm_sel_e    sel;
    logic [31:0] target;
  } entry_t;

  // Value every entry slot holds when it carries no instruction.
  function automatic entry_t nop_entry(input logic [31:0] nop_ir);
    entry_t e;
    e.ir     = nop_ir;
    e.pc     = 32'h0;
    e.imm    = 32'h0;
    e.sel    = SEL_NONE;
    e.target = 32'h0;
    return e;
  endfunction

endpackage

// File: rtl/decode_imm_stage_imm_type_decode.sv
// Combinational RV32I immediate extraction: classifies the opcode and forms
// the sign/zero-extended immediate for that format.
module imm_type_decode
  import decode_imm_stage_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [31:0] o_imm,
  output imm_sel_e    o_sel
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_imm = 32'h0;
    o_sel = SEL_NONE;
    unique case (i_ir[6:0])
      OP_LUI, OP_AUIPC: begin
        o_sel = SEL_U;
        o_imm = {i_ir[31:12], 12'b0};
      end
      OP_JAL: begin
        o_sel = SEL_J;
        o_imm = {{12{i_ir[31]}}, i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        o_sel = SEL_I;
        o_imm = {{20{i_ir[31]}}, i_ir[31:20]};
      end
      OP_STORE: begin
        o_sel = SEL_S;
        o_imm = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
      end
      OP_BRANCH: begin
        o_sel = SEL_B;
        o_imm = {{20{i_ir[31]}}, i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_imm_stage.sv
// Decode stage with a two-entry in-order skid buffer; immediate, type and
// branch target are formed on the input side and travel with each entry.
module decode_imm_stage
  import decode_imm_stage_pkg::*;
#(
  parameter logic [31:0] NOP_IR = NOP_IR_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ir,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ir,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [2:0]  out_imm_sel,
  output logic [31:0] out_target,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]  r_state;
  entry_t      r_head;
  entry_t      r_skid;
  logic [15:0] r_stall_cnt;

  logic [31:0] w_imm;
  imm_sel_e    w_sel;
  entry_t      w_in_entry;
  logic        w_accept;
  logic        w_retire;

  imm_type_decode u_imm_type_decode (
    .i_ir  (in_ir),
    .o_imm (w_imm),
    .o_sel (w_sel)
  );

  always_comb begin
    w_in_entry.ir     = in_ir;
    w_in_entry.pc     = in_pc;
    w_in_entry.imm    = w_imm;
    w_in_entry.sel    = w_sel;
    w_in_entry.target = in_pc + w_imm;
  end

  assign in_ready  = (r_state != ST_SKID) && !RST;
  assign out_valid = (r_state == ST_HOLD) || (r_state == ST_SKID);
  assign w_accept  = in_valid && in_ready;
  assign w_retire  = out_valid && out_ready;

  // Head slot is reloaded with the NOP entry whenever the buffer empties,
  // so the outputs need no mux on state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_EMPTY;
      r_head      <= nop_entry(NOP_IR);
      r_skid      <= nop_entry(NOP_IR);
      r_stall_cnt <= 16'h0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (flush) begin
        r_state <= ST_EMPTY;
        r_head  <= nop_entry(NOP_IR);
        r_skid  <= nop_entry(NOP_IR);
      end else begin
        case (r_state)
          ST_EMPTY: if (w_accept) begin
            r_head  <= w_in_entry;
            r_state <= ST_HOLD;
          end
          ST_HOLD: begin
            if (w_accept && w_retire) begin
              r_head <= w_in_entry;
            end else if (w_accept) begin
              r_skid  <= w_in_entry;
              r_state <= ST_SKID;
            end else if (w_retire) begin
              r_head  <= nop_entry(NOP_IR);
              r_state <= ST_EMPTY;
            end
          end
          ST_SKID: if (w_retire) begin
            r_head  <= r_skid;
            r_skid  <= nop_entry(NOP_IR);
            r_state <= ST_HOLD;
          end
          default: begin
            r_state <= ST_EMPTY;
            r_head  <= nop_entry(NOP_IR);
            r_skid  <= nop_entry(NOP_IR);
          end
        endcase
      end
    end
  end

  assign out_ir      = r_head.ir;
  assign out_pc      = r_head.pc;
  assign out_imm     = r_head.imm;
  assign out_imm_sel = r_head.sel;
  assign out_target  = r_head.target;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Directed bench for decode_imm_stage: hand-computed immediates, skid-buffer
// ordering, flush and reset behaviour.
module tb_decode_imm_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ir;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_sel;
  logic [31:0] out_target;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  decode_imm_stage dut (
    .CLK         (CLK),
    .RST         (RST),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ir       (in_ir),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ir      (out_ir),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_imm_sel (out_imm_sel),
    .out_target  (out_target),
    .stall_cnt   (stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc);
    in_valid = v;
    in_ir    = ir;
    in_pc    = pc;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [2:0] sel,
                          input logic [31:0] tgt);
    chk({tag, ".valid"},  {31'b0, out_valid},   32'd1);
    chk({tag, ".ir"},     out_ir,               ir);
    chk({tag, ".pc"},     out_pc,               pc);
    chk({tag, ".imm"},    out_imm,              imm);
    chk({tag, ".sel"},    {29'b0, out_imm_sel}, {29'b0, sel});
    chk({tag, ".target"}, out_target,           tgt);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"},  {31'b0, out_valid},   32'd0);
    chk({tag, ".ir"},     out_ir,               32'h00000013);
    chk({tag, ".pc"},     out_pc,               32'h0);
    chk({tag, ".imm"},    out_imm,              32'h0);
    chk({tag, ".sel"},    {29'b0, out_imm_sel}, 32'h0);
    chk({tag, ".target"}, out_target,           32'h0);
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    chk_empty("rst");
    chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst.stall", {16'b0, stall_cnt}, 32'd0);
    RST = 1'b0; #1;
    chk("rst_rel.in_ready", {31'b0, in_ready}, 32'd1);

    // addi x1,x0,-1 at 0x100
    drive(1'b1, 32'hFFF00093, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0); out_ready = 1'b1;
    chk_head("itype", 32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 32'h000000FF);
    tick();
    chk_empty("itype_ret");

    // beq -4 at 0x200
    out_ready = 1'b0;
    drive(1'b1, 32'hFE000EE3, 32'h200);
    tick();
    drive(1'b0, 32'h0, 32'h0); out_ready = 1'b1;
    chk_head("btype", 32'hFE000EE3, 32'h200, 32'hFFFFFFFC, 3'd3, 32'h000001FC);
    tick();
    chk_empty("btype_ret");
    chk("btype.stall", {16'b0, stall_cnt}, 32'd0);

    // lui then jal streamed back-to-back
    drive(1'b1, 32'h123452B7, 32'h0);
    tick();
    chk_head("stream_u", 32'h123452B7, 32'h0, 32'h12345000, 3'd4, 32'h12345000);
    drive(1'b1, 32'h0080006F, 32'h4);
    tick();
    chk_head("stream_j", 32'h0080006F, 32'h4, 32'h00000008, 3'd5, 32'h0000000C);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk_empty("stream_end");

    // back-pressure: A, B fill the buffer, C must wait
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h10);
    tick();
    chk("bp1.in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp1.stall", {16'b0, stall_cnt}, 32'd0);
    drive(1'b1, 32'h00A00113, 32'h14);
    tick();
    chk("bp2.in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp2.stall", {16'b0, stall_cnt}, 32'd1);
    chk("bp2.ir", out_ir, 32'h00500093);
    drive(1'b1, 32'h00C00193, 32'h18);
    tick();
    chk("bp3.in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp3.stall", {16'b0, stall_cnt}, 32'd2);
    chk_head("bp3", 32'h00500093, 32'h10, 32'h5, 3'd1, 32'h15);
    tick();
    chk("bp4.stall", {16'b0, stall_cnt}, 32'd3);
    chk_head("bp4", 32'h00500093, 32'h10, 32'h5, 3'd1, 32'h15);
    out_ready = 1'b1;
    tick();
    chk_head("bp_b", 32'h00A00113, 32'h14, 32'hA, 3'd1, 32'h1E);
    chk("bp_b.in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_b.stall", {16'b0, stall_cnt}, 32'd3);
    tick();
    chk_head("bp_c", 32'h00C00193, 32'h18, 32'hC, 3'd1, 32'h24);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk_empty("bp_end");

    // flush while in SKID with a same-cycle input
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h10);
    tick();
    drive(1'b1, 32'h00A00113, 32'h14);
    tick();
    chk("fl.in_ready_skid", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00C00193, 32'h18);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk_empty("flush");
    chk("flush.in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush.stall", {16'b0, stall_cnt}, 32'd5);

    // reset while HOLD clears stall count
    drive(1'b1, 32'h00500093, 32'h10);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("hold.valid", {31'b0, out_valid}, 32'd1);
    chk("hold.stall", {16'b0, stall_cnt}, 32'd5);
    RST = 1'b1;
    tick();
    chk_empty("rst_hold");
    chk("rst_hold.stall", {16'b0, stall_cnt}, 32'd0);
    chk("rst_hold.in_ready", {31'b0, in_ready}, 32'd0);
    RST = 1'b0; #1;
    chk("rst_hold_rel.in_ready", {31'b0, in_ready}, 32'd1);

    // store and a non-immediate op
    out_ready = 1'b1;
    drive(1'b1, 32'hFE512C23, 32'h40);
    tick();
    chk_head("stype", 32'hFE512C23, 32'h40, 32'hFFFFFFF8, 3'd2, 32'h38);
    drive(1'b1, 32'h00000033, 32'h44);
    tick();
    chk_head("none", 32'h00000033, 32'h44, 32'h0, 3'd0, 32'h44);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk_empty("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
